// File: rtl/cam_line_pkt_sched.sv
// Capture-side line scheduler: ping-pong line banks between the 16-bit
// pixel stream and the UDP packet builder, one packet request per line.
module cam_line_pkt_sched #(
  parameter int H_MAX       = 1024,
  parameter int ADDR_W      = 10,
  parameter int SKIP_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_init_done,
  input  logic              vsync,
  input  logic              pix_de,
  input  logic              pix_valid,
  input  logic [15:0]       pix_data,
  output logic              pkt_req,
  input  logic              pkt_ack,
  output logic [15:0]       pkt_frame_id,
  output logic [15:0]       pkt_line_id,
  output logic [ADDR_W:0]   pkt_len,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  input  logic              pkt_done,
  output logic [15:0]       drop_cnt,
  output logic              capturing
);
  typedef enum logic [1:0] {WAIT_INIT, SKIP, WAIT_VS, CAPTURE} cap_t;
  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_BUSY} tx_t;

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(H_MAX);

  cap_t cs, cs_n;
  tx_t  tx, tx_n;

  logic              vs_q, de_q;
  logic [7:0]        skip_cnt;
  logic [15:0]       frame_id, line_id;
  logic [1:0]        used, used_a, used_n;
  logic              line_open, line_drop, cur_bank;
  logic [ADDR_W:0]   wcnt;
  logic              q_head, q_head_p;
  logic [1:0]        q_cnt, q_cnt_p;
  logic [15:0]       fid [2];
  logic [15:0]       lid [2];
  logic [ADDR_W:0]   blen [2];
  logic [15:0]       mem0 [H_MAX];
  logic [15:0]       mem1 [H_MAX];

  logic vs_rise, de_rise, de_fall;
  logic frame_start, abort, cap_ev;
  logic line_start, line_end, tx_done;
  logic claim0, claim1, drop, push, wr;

  assign vs_rise   = vsync & ~vs_q;
  assign de_rise   = pix_de & ~de_q;
  assign de_fall   = ~pix_de & de_q;
  assign capturing = (cs == CAPTURE);

  always_comb begin
    cs_n        = cs;
    frame_start = 1'b0;
    unique case (cs)
      WAIT_INIT: if (cam_init_done) cs_n = SKIP;
      SKIP: begin
        if (SKIP_FRAMES == 0) begin
          cs_n = WAIT_VS;
        end else if (vs_rise &&
                     (skip_cnt + 8'd1 == 8'(SKIP_FRAMES))) begin
          cs_n        = CAPTURE;
          frame_start = 1'b1;
        end
      end
      WAIT_VS: if (vs_rise) begin
        cs_n        = CAPTURE;
        frame_start = 1'b1;
      end
      CAPTURE: begin
        if (!cam_init_done) cs_n = WAIT_INIT;
        else frame_start = vs_rise;
      end
      default: cs_n = WAIT_INIT;
    endcase
  end

  assign abort      = (cs == CAPTURE && !cam_init_done) || frame_start;
  assign cap_ev     = (cs_n == CAPTURE);
  assign line_start = cap_ev && de_rise;
  assign line_end   = cap_ev && de_fall && !frame_start &&
                      (line_open || line_drop);
  assign tx_done    = (tx == TX_BUSY) && pkt_done;
  assign push       = line_end && line_open && (wcnt != '0);
  assign wr         = (cs == CAPTURE) && !abort && line_open &&
                      pix_de && pix_valid && (wcnt < LEN_MAX);

  // A bank released this cycle (done or abort) is already claimable.
  always_comb begin
    used_a = used;
    if (tx_done) used_a[q_head] = 1'b0;
    if (abort && line_open) used_a[cur_bank] = 1'b0;
    claim0 = line_start && !used_a[0];
    claim1 = line_start && used_a[0] && !used_a[1];
    drop   = line_start && (&used_a);
    used_n = used_a;
    if (claim0) used_n[0] = 1'b1;
    if (claim1) used_n[1] = 1'b1;
    if (line_end && line_open && wcnt == '0) used_n[cur_bank] = 1'b0;
  end

  // Two banks: the queue entry behind the head is always the other bank.
  always_comb begin
    q_cnt_p  = q_cnt - {1'b0, tx_done};
    q_head_p = tx_done ? ~q_head : q_head;
  end

  always_comb begin
    tx_n = tx;
    unique case (tx)
      TX_IDLE: if (q_cnt != 2'd0) tx_n = TX_REQ;
      TX_REQ:  if (pkt_ack) tx_n = TX_BUSY;
      TX_BUSY: if (pkt_done) tx_n = TX_IDLE;
      default: tx_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs           <= WAIT_INIT;
      tx           <= TX_IDLE;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      skip_cnt     <= '0;
      frame_id     <= 16'hFFFF;
      line_id      <= '0;
      used         <= '0;
      line_open    <= 1'b0;
      line_drop    <= 1'b0;
      cur_bank     <= 1'b0;
      wcnt         <= '0;
      q_head       <= 1'b0;
      q_cnt        <= '0;
      drop_cnt     <= '0;
      pkt_req      <= 1'b0;
      pkt_frame_id <= '0;
      pkt_line_id  <= '0;
      pkt_len      <= '0;
    end else begin
      cs   <= cs_n;
      tx   <= tx_n;
      vs_q <= vsync;
      de_q <= pix_de;
      used <= used_n;
      if (cs == WAIT_INIT) skip_cnt <= '0;
      else if (cs == SKIP && vs_rise) skip_cnt <= skip_cnt + 8'd1;
      if (abort) begin
        line_open <= 1'b0;
        line_drop <= 1'b0;
      end
      if (frame_start) begin
        frame_id <= frame_id + 16'd1;
        line_id  <= '0;
      end
      if (line_start) begin
        line_open <= claim0 | claim1;
        line_drop <= drop;
        cur_bank  <= claim1;
        wcnt      <= '0;
        if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      if (wr) wcnt <= wcnt + 1'b1;
      if (line_end) begin
        line_open <= 1'b0;
        line_drop <= 1'b0;
        line_id   <= line_id + 16'd1;
      end
      if (push) begin
        q_head <= (q_cnt_p == 2'd0) ? cur_bank : q_head_p;
        q_cnt  <= q_cnt_p + 2'd1;
      end else begin
        q_head <= q_head_p;
        q_cnt  <= q_cnt_p;
      end
      if (tx == TX_IDLE && q_cnt != 2'd0) begin
        pkt_req      <= 1'b1;
        pkt_frame_id <= fid[q_head];
        pkt_line_id  <= lid[q_head];
        pkt_len      <= blen[q_head];
      end
      if (tx == TX_REQ && pkt_ack) pkt_req <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fid[cur_bank]  <= frame_id;
      lid[cur_bank]  <= line_id;
      blen[cur_bank] <= wcnt;
    end
    if (wr) begin
      if (cur_bank) mem1[wcnt[ADDR_W-1:0]] <= pix_data;
      else          mem0[wcnt[ADDR_W-1:0]] <= pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data <= '0;
    else if (tx == TX_BUSY && rd_en)
      rd_data <= q_head ? mem1[rd_addr] : mem0[rd_addr];
  end
endmodule

// File: tb/tb_cam_line_pkt_sched.sv
// Scoreboard bench for cam_line_pkt_sched: expected packets and pixels
// are queued as lines are driven and checked as the DUT offers them.
module tb_cam_line_pkt_sched;
  localparam int H_MAX  = 1024;
  localparam int ADDR_W = 10;

  typedef struct packed {
    logic [15:0]     fid;
    logic [15:0]     lid;
    logic [ADDR_W:0] len;
  } hdr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cam_init_done = 1'b0;
  logic              vsync = 1'b0;
  logic              pix_de = 1'b0;
  logic              pix_valid = 1'b0;
  logic [15:0]       pix_data = '0;
  logic              pkt_ack = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              pkt_done = 1'b0;
  logic              pkt_req;
  logic [15:0]       pkt_frame_id;
  logic [15:0]       pkt_line_id;
  logic [ADDR_W:0]   pkt_len;
  logic [15:0]       rd_data;
  logic [15:0]       drop_cnt;
  logic              capturing;

  int          vectors = 0;
  int          miscompares = 0;
  hdr_t        hdrq[$];
  logic [15:0] pixq[$];
  logic [15:0] m_fid = 16'hFFFF;
  logic [15:0] m_lid = '0;
  logic [15:0] m_drop = '0;
  int          cur_len = 0;

  cam_line_pkt_sched #(.H_MAX(H_MAX), .ADDR_W(ADDR_W), .SKIP_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cam_init_done(cam_init_done),
    .vsync(vsync), .pix_de(pix_de), .pix_valid(pix_valid),
    .pix_data(pix_data), .pkt_req(pkt_req), .pkt_ack(pkt_ack),
    .pkt_frame_id(pkt_frame_id), .pkt_line_id(pkt_line_id),
    .pkt_len(pkt_len), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .pkt_done(pkt_done), .drop_cnt(drop_cnt),
    .capturing(capturing)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic vs_pulse(input bit fs);
    vsync = 1'b1; tick();
    vsync = 1'b0; tick(); tick();
    if (fs) begin m_fid = m_fid + 16'd1; m_lid = '0; end
  endtask

  task automatic send_line(input int n, input bit exp);
    int len;
    len = (n > H_MAX) ? H_MAX : n;
    pix_de = 1'b1; tick();
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data  = 16'($urandom);
      if (exp && i < H_MAX) pixq.push_back(pix_data);
      tick();
    end
    pix_valid = 1'b0; pix_de = 1'b0; tick(); tick();
    if (exp) hdrq.push_back('{m_fid, m_lid, (ADDR_W+1)'(len)});
    m_lid = m_lid + 16'd1;
  endtask

  task automatic accept_pkt(output bit ok);
    int t;
    hdr_t h;
    ok = 1'b0; t = 0; cur_len = 0;
    while (pkt_req !== 1'b1 && t < 500) begin tick(); t++; end
    vectors++;
    if (pkt_req !== 1'b1) begin
      $display("FAIL pkt_req_timeout: pkt_req=%b required 1", pkt_req);
      miscompares++;
      return;
    end
    if (hdrq.size() == 0) begin
      $display("FAIL unexpected_pkt: line %0d offered, required none",
               pkt_line_id);
      miscompares++;
      return;
    end
    h = hdrq.pop_front();
    cur_len = int'(h.len);
    vectors++;
    if ({pkt_frame_id, pkt_line_id, pkt_len} !== h) begin
      $display("FAIL pkt_hdr: got fid=%h lid=%0d len=%0d required fid=%h lid=%0d len=%0d",
               pkt_frame_id, pkt_line_id, pkt_len, h.fid, h.lid, h.len);
      miscompares++;
    end
    pkt_ack = 1'b1; tick(); pkt_ack = 1'b0;
    vectors++;
    if (pkt_req !== 1'b0) begin
      $display("FAIL pkt_req_drop: pkt_req=%b required 0", pkt_req);
      miscompares++;
    end
    ok = 1'b1;
  endtask

  task automatic readback();
    logic [15:0] e, g_bad, e_bad;
    int bad, a_bad;
    bad = 0; a_bad = 0; g_bad = '0; e_bad = '0;
    for (int a = 0; a < cur_len; a++) begin
      rd_en = 1'b1; rd_addr = ADDR_W'(a); tick();
      e = (pixq.size() > 0) ? pixq.pop_front() : 16'hxxxx;
      if (rd_data !== e) begin
        if (bad == 0) begin a_bad = a; g_bad = rd_data; e_bad = e; end
        bad++;
      end
    end
    rd_en = 1'b0;
    vectors++;
    if (bad != 0) begin
      $display("FAIL rd_data: %0d bad words, first addr %0d got %h required %h",
               bad, a_bad, g_bad, e_bad);
      miscompares++;
    end
  endtask

  task automatic finish_pkt();
    pkt_done = 1'b1; tick(); pkt_done = 1'b0; tick();
  endtask

  task automatic serve_pkt();
    bit ok;
    accept_pkt(ok);
    if (ok) begin readback(); finish_pkt(); end
  endtask

  task automatic expect_quiet(input int n, input string tag);
    bit seen;
    seen = 1'b0;
    repeat (n) begin tick(); if (pkt_req !== 1'b0) seen = 1'b1; end
    vectors++;
    if (seen) begin
      $display("FAIL %s: pkt_req rose, required no request", tag);
      miscompares++;
    end
  endtask

  task automatic check_drop(input string tag);
    vectors++;
    if (drop_cnt !== m_drop) begin
      $display("FAIL %s: drop_cnt=%0d required %0d", tag, drop_cnt, m_drop);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
    vectors++;
    if ({pkt_req, capturing} !== 2'b00) begin
      $display("FAIL reset_flags: req/cap=%b required 00", {pkt_req, capturing});
      miscompares++;
    end
    vectors++;
    if ({pkt_frame_id, pkt_line_id, pkt_len} !== '0) begin
      $display("FAIL reset_hdr: got %h required 0",
               {pkt_frame_id, pkt_line_id, pkt_len});
      miscompares++;
    end
    vectors++;
    if (rd_data !== 16'h0) begin
      $display("FAIL reset_rd_data: got %h required 0000", rd_data);
      miscompares++;
    end
    check_drop("reset_drop_cnt");
  endtask

  task automatic test_startup();
    cam_init_done = 1'b1; tick(); tick();
    vs_pulse(1'b0);
    vectors++;
    if (capturing !== 1'b0) begin
      $display("FAIL startup_vs1: capturing=%b required 0", capturing);
      miscompares++;
    end
    vs_pulse(1'b1);
    vectors++;
    if (capturing !== 1'b1) begin
      $display("FAIL startup_vs2: capturing=%b required 1", capturing);
      miscompares++;
    end
    send_line(1024, 1'b1);
    serve_pkt();
  endtask

  task automatic test_back_pressure();
    vs_pulse(1'b1);
    send_line(8, 1'b1);
    send_line(8, 1'b1);
    send_line(8, 1'b0);
    m_drop = m_drop + 16'd1;
    check_drop("bp_drop_cnt");
    serve_pkt();
    serve_pkt();
    expect_quiet(40, "bp_dropped_line");
  endtask

  task automatic test_trunc_empty();
    vs_pulse(1'b1);
    send_line(1100, 1'b1);
    send_line(0, 1'b0);
    send_line(8, 1'b1);
    serve_pkt();
    serve_pkt();
    expect_quiet(40, "empty_line");
  endtask

  task automatic test_midline_vsync();
    vs_pulse(1'b1);
    for (int l = 0; l < 5; l++) begin send_line(8, 1'b1); serve_pkt(); end
    pix_de = 1'b1; tick();
    for (int i = 0; i < 500; i++) begin
      pix_valid = 1'b1; pix_data = 16'($urandom); tick();
    end
    pix_valid = 1'b0; vsync = 1'b1; tick();
    vsync = 1'b0; pix_de = 1'b0; tick(); tick();
    m_fid = m_fid + 16'd1; m_lid = '0;
    expect_quiet(20, "aborted_line");
    check_drop("mid_drop_cnt");
    send_line(8, 1'b1);
    serve_pkt();
  endtask

  task automatic test_same_cycle();
    bit ok;
    send_line(16, 1'b1);
    send_line(16, 1'b1);
    accept_pkt(ok);
    readback();
    pkt_done = 1'b1; pix_de = 1'b1; tick();
    pkt_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pix_valid = 1'b1; pix_data = 16'($urandom);
      pixq.push_back(pix_data); tick();
    end
    pix_valid = 1'b0; pix_de = 1'b0; tick(); tick();
    hdrq.push_back('{m_fid, m_lid, (ADDR_W+1)'(12)});
    m_lid = m_lid + 16'd1;
    check_drop("same_cycle_drop_cnt");
    serve_pkt();
    serve_pkt();
  endtask

  task automatic test_reset_busy();
    bit ok;
    send_line(8, 1'b1);
    accept_pkt(ok);
    cam_init_done = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    hdrq.delete(); pixq.delete();
    m_fid = 16'hFFFF; m_lid = '0; m_drop = '0;
    vectors++;
    if ({pkt_req, capturing} !== 2'b00) begin
      $display("FAIL rst_busy_flags: req/cap=%b required 00",
               {pkt_req, capturing});
      miscompares++;
    end
    check_drop("rst_busy_drop_cnt");
    vs_pulse(1'b0); vs_pulse(1'b0); vs_pulse(1'b0);
    vectors++;
    if (capturing !== 1'b0) begin
      $display("FAIL rst_wait_init: capturing=%b required 0", capturing);
      miscompares++;
    end
    expect_quiet(10, "rst_no_pkt");
    cam_init_done = 1'b1; tick(); tick();
    vs_pulse(1'b0); vs_pulse(1'b1);
    vectors++;
    if (capturing !== 1'b1) begin
      $display("FAIL rst_recapture: capturing=%b required 1", capturing);
      miscompares++;
    end
    send_line(8, 1'b1);
    serve_pkt();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_back_pressure();
    test_trunc_empty();
    test_midline_vsync();
    test_same_cycle();
    test_reset_busy();
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
